// File: rtl/music_player.sv
// Note sequencer and square-wave tone generator: steps through the note ROM
// at a fixed tempo and drives the speaker pin with the decoded pitch.
module music_player #(
    parameter int unsigned TEMPO_DIV = 25000000,
    parameter logic [7:0]  LAST_ADDR = 8'd240,
    parameter bit          LOOP      = 1'b1,
    parameter int unsigned ROM_LAT   = 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       enable,
    input  logic       restart,
    input  logic [7:0] note_in,
    output logic [7:0] address,
    output logic       speaker,
    output logic       playing,
    output logic       done
);

    localparam int TW = $clog2(TEMPO_DIV);
    localparam int FW = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
    localparam logic [TW-1:0] TEMPO_LAST = TW'(TEMPO_DIV - 1);
    localparam logic [FW-1:0] FETCH_LAST = FW'(ROM_LAT - 1);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        PLAY  = 2'd2,
        DONE  = 2'd3
    } state_t;

    state_t state, state_next;

    logic [TW-1:0] tempo_cnt;
    logic [FW-1:0] fetch_cnt;
    logic [19:0]   tone_cnt;
    logic [19:0]   half_period;
    logic [7:0]    active_note;

    logic tempo_end;
    logic fetch_end;
    logic stay_fetch;
    logic stay_play;
    logic latch_note;
    logic step_now;
    logic tone_wrap;

    // Half-period in clk cycles for a note; zero marks a rest.
    function automatic logic [19:0] decode_note(input logic [7:0] note);
        logic [19:0] base;
        logic [7:0]  octave;
        logic [7:0]  pitch;
        octave = note / 8'd12;
        pitch  = note % 8'd12;
        case (pitch)
            8'd0:    base = 20'd764409;
            8'd1:    base = 20'd721501;
            8'd2:    base = 20'd681013;
            8'd3:    base = 20'd642797;
            8'd4:    base = 20'd606722;
            8'd5:    base = 20'd572672;
            8'd6:    base = 20'd540530;
            8'd7:    base = 20'd510204;
            8'd8:    base = 20'd481579;
            8'd9:    base = 20'd454545;
            8'd10:   base = 20'd429037;
            default: base = 20'd404957;
        endcase
        if (note == 8'd0 || note >= 8'd96) begin
            decode_note = 20'd0;
        end else begin
            decode_note = base >> octave[2:0];
        end
    endfunction

    assign tempo_end  = (tempo_cnt == TEMPO_LAST);
    assign fetch_end  = (fetch_cnt == FETCH_LAST);
    assign stay_fetch = !restart && (state == FETCH) && (state_next == FETCH);
    assign stay_play  = !restart && (state == PLAY) && (state_next == PLAY);
    assign latch_note = !restart && (state == FETCH) && (state_next == PLAY);
    assign step_now   = !restart && (state == PLAY) && enable && tempo_end;
    assign tone_wrap  = (half_period != 20'd0) && (tone_cnt == half_period - 20'd1);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Restart overrides everything, including a tempo step landing in the same cycle.
    always_comb begin
        state_next = state;
        playing    = 1'b0;
        done       = 1'b0;
        if (restart) begin
            state_next = enable ? FETCH : IDLE;
        end else begin
            case (state)
                IDLE: begin
                    if (enable) state_next = FETCH;
                end
                FETCH: begin
                    if (!enable)        state_next = IDLE;
                    else if (fetch_end) state_next = PLAY;
                end
                PLAY: begin
                    if (!enable) begin
                        state_next = IDLE;
                    end else if (tempo_end) begin
                        state_next = (address == LAST_ADDR && !LOOP) ? DONE : FETCH;
                    end
                end
                default: state_next = DONE;
            endcase
        end
        playing = (state == FETCH) || (state == PLAY);
        done    = (state == DONE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            address <= 8'd0;
        end else if (restart) begin
            address <= 8'd0;
        end else if (step_now) begin
            if (address != LAST_ADDR) begin
                address <= address + 8'd1;
            end else if (LOOP) begin
                address <= 8'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt <= '0;
            tempo_cnt <= '0;
        end else begin
            fetch_cnt <= stay_fetch ? fetch_cnt + 1'b1 : '0;
            tempo_cnt <= stay_play ? tempo_cnt + 1'b1 : '0;
        end
    end

    // The ROM output is valid on the last FETCH cycle, so it is decoded right there
    // and half_period is ready on the first PLAY cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            active_note <= 8'd0;
            half_period <= 20'd0;
        end else if (latch_note) begin
            active_note <= note_in;
            half_period <= decode_note(note_in);
        end
    end

    // Leaving PLAY for any reason clears the tone phase, so every note starts low.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tone_cnt <= 20'd0;
            speaker  <= 1'b0;
        end else if (stay_play && half_period != 20'd0) begin
            if (tone_wrap) begin
                tone_cnt <= 20'd0;
                speaker  <= ~speaker;
            end else begin
                tone_cnt <= tone_cnt + 20'd1;
            end
        end else begin
            tone_cnt <= 20'd0;
            speaker  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_music_player.sv
// Bench for music_player: three instances (looping, one-shot, long-tempo tone)
// each fed by a 2-cycle ROM model and checked against a step/phase model.
module tb_music_player;

    localparam int STEP_TD  = 8;
    localparam int TONE_TD  = 10000;
    localparam int BASE_TAB [12] = '{764409, 721501, 681013, 642797, 606722, 572672,
                                     540530, 510204, 481579, 454545, 429037, 404957};

    typedef struct {
        int addr;
        int phase;
        bit active;
        bit done;
    } model_t;

    typedef struct {
        bit en;
        bit rs;
        int cycles;
        int addr;
        bit playing;
        bit done;
    } vec_t;

    logic clk;
    int   vectors;
    int   miscompares;

    logic       rst_main, en_main, rs_main, spk_main, play_main, done_main;
    logic [7:0] note_main, addr_main;
    logic       rst_stop, en_stop, rs_stop, spk_stop, play_stop, done_stop;
    logic [7:0] note_stop, addr_stop;
    logic       rst_tone, en_tone, rs_tone, spk_tone, play_tone, done_tone;
    logic [7:0] note_tone, addr_tone;

    logic [7:0] rom_main [256];
    logic [7:0] rom_stop [256];
    logic [7:0] rom_tone [256];

    music_player #(.TEMPO_DIV(STEP_TD), .LAST_ADDR(8'd7), .LOOP(1'b1), .ROM_LAT(2)) dut_main (
        .clk(clk), .reset(rst_main), .enable(en_main), .restart(rs_main), .note_in(note_main),
        .address(addr_main), .speaker(spk_main), .playing(play_main), .done(done_main));

    music_player #(.TEMPO_DIV(STEP_TD), .LAST_ADDR(8'd3), .LOOP(1'b0), .ROM_LAT(2)) dut_stop (
        .clk(clk), .reset(rst_stop), .enable(en_stop), .restart(rs_stop), .note_in(note_stop),
        .address(addr_stop), .speaker(spk_stop), .playing(play_stop), .done(done_stop));

    music_player #(.TEMPO_DIV(TONE_TD), .LAST_ADDR(8'd240), .LOOP(1'b1), .ROM_LAT(2)) dut_tone (
        .clk(clk), .reset(rst_tone), .enable(en_tone), .restart(rs_tone), .note_in(note_tone),
        .address(addr_tone), .speaker(spk_tone), .playing(play_tone), .done(done_tone));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ROM models: data for an address is visible one edge after it is presented,
    // i.e. on the second cycle counted from the address change.
    always @(posedge clk) begin
        note_main <= rom_main[addr_main];
        note_stop <= rom_stop[addr_stop];
        note_tone <= rom_tone[addr_tone];
    end

    function automatic int half_period(input int note);
        return BASE_TAB[note % 12] / (1 << (note / 12));
    endfunction

    // One clock of the song timeline: a step is fetch (phases 0,1) plus td play phases.
    function automatic model_t model_step(input model_t m, input bit en, input bit rs,
                                          input int last, input bit loop, input int td);
        model_t n;
        n = m;
        if (rs) begin
            n.addr = 0; n.phase = 0; n.done = 1'b0; n.active = en;
        end else if (m.done) begin
            n = m;
        end else if (!m.active) begin
            if (en) begin n.active = 1'b1; n.phase = 0; end
        end else if (!en) begin
            n.active = 1'b0;
        end else if (m.phase == td + 1) begin
            n.phase = 0;
            if (m.addr < last)  n.addr = m.addr + 1;
            else if (loop)      n.addr = 0;
            else begin n.active = 1'b0; n.done = 1'b1; end
        end else begin
            n.phase = m.phase + 1;
        end
        return n;
    endfunction

    function automatic int exp_speaker(input model_t m, input int note);
        if (!m.active || m.phase < 2 || note == 0 || note >= 96) return 0;
        return ((m.phase - 2) / half_period(note)) % 2;
    endfunction

    task automatic checkOutput(input string name, input int actual, input int expected);
        vectors++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input bit en, input bit rs);
        en_main = en;
        rs_main = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic run_main();
        vec_t   vt [12];
        model_t m;
        bit     en, rs;
        vt[0]  = '{1'b0, 1'b0, 3,  0, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 1,  0, 1'b1, 1'b0};
        vt[2]  = '{1'b1, 1'b0, 9,  0, 1'b1, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 1,  1, 1'b1, 1'b0};
        vt[4]  = '{1'b1, 1'b0, 40, 5, 1'b1, 1'b0};
        vt[5]  = '{1'b1, 1'b0, 5,  5, 1'b1, 1'b0};
        vt[6]  = '{1'b0, 1'b0, 1,  5, 1'b0, 1'b0};
        vt[7]  = '{1'b0, 1'b0, 4,  5, 1'b0, 1'b0};
        vt[8]  = '{1'b1, 1'b0, 1,  5, 1'b1, 1'b0};
        vt[9]  = '{1'b1, 1'b0, 10, 6, 1'b1, 1'b0};
        vt[10] = '{1'b1, 1'b1, 1,  0, 1'b1, 1'b0};
        vt[11] = '{1'b0, 1'b1, 1,  0, 1'b0, 1'b0};
        for (int r = 0; r < 12; r++) begin
            for (int c = 0; c < vt[r].cycles; c++) begin
                applyStimulus(vt[r].en, (c == 0) ? vt[r].rs : 1'b0);
            end
            checkOutput($sformatf("row%0d address", r), int'(addr_main), vt[r].addr);
            checkOutput($sformatf("row%0d playing", r), int'(play_main), int'(vt[r].playing));
            checkOutput($sformatf("row%0d done", r), int'(done_main), int'(vt[r].done));
            checkOutput($sformatf("row%0d speaker", r), int'(spk_main), 0);
        end
        m = '{0, 0, 1'b0, 1'b0};
        for (int i = 0; i < 800; i++) begin
            en = ($urandom_range(0, 9) != 0);
            rs = ($urandom_range(0, 39) == 0);
            applyStimulus(en, rs);
            m = model_step(m, en, rs, 7, 1'b1, STEP_TD);
            checkOutput("rand address", int'(addr_main), m.addr);
            checkOutput("rand playing", int'(play_main), int'(m.active));
            checkOutput("rand done", int'(done_main), int'(m.done));
            checkOutput("rand speaker", int'(spk_main), exp_speaker(m, int'(rom_main[m.addr])));
        end
    endtask

    task automatic stop_tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_stop();
        en_stop = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            stop_tick();
            if (k == 11) checkOutput("stop addr after first step", int'(addr_stop), 1);
        end
        checkOutput("stop last play addr", int'(addr_stop), 3);
        checkOutput("stop last play done", int'(done_stop), 0);
        checkOutput("stop last play playing", int'(play_stop), 1);
        stop_tick();
        checkOutput("stop done", int'(done_stop), 1);
        checkOutput("stop done playing", int'(play_stop), 0);
        checkOutput("stop done addr", int'(addr_stop), 3);
        checkOutput("stop done speaker", int'(spk_stop), 0);
        for (int k = 0; k < 20; k++) stop_tick();
        checkOutput("stop held done", int'(done_stop), 1);
        checkOutput("stop held addr", int'(addr_stop), 3);
        rs_stop = 1'b1;
        stop_tick();
        rs_stop = 1'b0;
        checkOutput("stop restart addr", int'(addr_stop), 0);
        checkOutput("stop restart done", int'(done_stop), 0);
        checkOutput("stop restart playing", int'(play_stop), 1);
        for (int k = 0; k < 10; k++) stop_tick();
        checkOutput("stop restart next addr", int'(addr_stop), 1);
    endtask

    task automatic run_tone();
        model_t m;
        m = '{0, 0, 1'b0, 1'b0};
        en_tone = 1'b1;
        for (int k = 1; k <= 43224; k++) begin
            @(posedge clk);
            #1;
            m = model_step(m, 1'b1, 1'b0, 240, 1'b1, TONE_TD);
            checkOutput("tone speaker", int'(spk_tone), exp_speaker(m, int'(rom_tone[m.addr])));
            checkOutput("tone address", int'(addr_tone), m.addr);
            checkOutput("tone playing", int'(play_tone), int'(m.active));
        end
        checkOutput("tone high before reset", int'(spk_tone), 1);
        @(negedge clk);
        rst_tone = 1'b1;
        #1;
        checkOutput("async reset speaker", int'(spk_tone), 0);
        checkOutput("async reset address", int'(addr_tone), 0);
        checkOutput("async reset playing", int'(play_tone), 0);
        checkOutput("async reset done", int'(done_tone), 0);
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        for (int i = 0; i < 256; i++) begin
            rom_main[i] = 8'($urandom_range(0, 127));
            rom_stop[i] = 8'd95;
            rom_tone[i] = 8'd0;
        end
        rom_main[0] = 8'd0;
        rom_main[1] = 8'd100;
        rom_tone[0] = 8'd95;
        rom_tone[1] = 8'd95;
        rom_tone[2] = 8'd84;
        rom_tone[3] = 8'd100;
        rom_tone[4] = 8'd95;
        {rst_main, rst_stop, rst_tone} = 3'b111;
        {en_main, en_stop, en_tone}    = 3'b000;
        {rs_main, rs_stop, rs_tone}    = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset address", int'(addr_main), 0);
        checkOutput("reset speaker", int'(spk_main), 0);
        checkOutput("reset playing", int'(play_main), 0);
        checkOutput("reset done", int'(done_main), 0);
        {rst_main, rst_stop, rst_tone} = 3'b000;
        fork
            run_main();
            run_stop();
            run_tone();
        join
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/music_player.md
Name: music_player

Overview:
- Sequencer/tone generator that reads the 256-entry note ROM (8-bit address in, registered 8-bit note out, 2-cycle read latency).
- Steps the ROM address at a fixed tempo and waits out the read latency.
- Decodes each note number into a square-wave half-period and drives the speaker pin.
- Sits between the ROM and the board audio output, controlled by the top-level play/restart inputs.

Parameters:
TEMPO_DIV, 25000000, clk cycles each ROM entry is held (one tempo step); minimum 4.
LAST_ADDR, 240, final ROM address played before wrap/stop.
LOOP, 1, 1 = wrap to address 0 after LAST_ADDR; 0 = stop and assert done.
ROM_LAT, 2, clk cycles from address change to valid note_in.

Ports:
clk  input  1  system clock (100 MHz nominal)
reset  input  1  asynchronous, active-high reset
enable  input  1  level; 1 = play, 0 = pause
restart  input  1  one-cycle pulse; restart song from address 0
note_in  input  8  note number from ROM (0 = rest)
address  output  8  ROM address
speaker  output  1  square-wave audio output
playing  output  1  1 while in FETCH or PLAY
done  output  1  1 when song finished (LOOP=0 only)

Behaviour:
- Reset values: address=0, speaker=0, playing=0, done=0, FSM=IDLE, all counters 0, active note=0 (rest).
- FSM states:
  - IDLE: enable=1 -> FETCH.
  - FETCH: waits ROM_LAT cycles after the address change, latches note_in into active_note on the last cycle, clears the tone counter, then -> PLAY.
  - PLAY: tempo counter runs 0..TEMPO_DIV-1. At the terminal count:
    - address<LAST_ADDR: address+1, -> FETCH.
    - address=LAST_ADDR, LOOP=1: address=0, -> FETCH.
    - address=LAST_ADDR, LOOP=0: -> DONE.
  - DONE: done=1, speaker=0, address held. Only restart or reset leaves DONE.
- Step length: each ROM entry is audible for exactly TEMPO_DIV cycles (PLAY) plus ROM_LAT cycles (FETCH). Step period = TEMPO_DIV+ROM_LAT cycles.
- enable=0 in FETCH/PLAY:
  - -> IDLE, speaker forced 0 next cycle.
  - Address held; tempo counter cleared.
  - Re-enable replays the current address from FETCH (the partial step is not resumed).
- restart:
  - From any state: address=0, counters cleared, done=0.
  - -> FETCH if enable=1, else IDLE.
  - Takes priority over the tempo terminal count in the same cycle.
- Note decode (combinational from active_note, registered into half_period):
  - active_note=0 or >=96: rest, speaker held 0.
  - Otherwise octave = note/12 (0..7), pitch = note%12.
  - half_period = BASE[pitch] >> octave, 20-bit.
  - BASE C..B = 764409, 721501, 681013, 642797, 606722, 572672, 540530, 510204, 481579, 454545, 429037, 404957.
- Tone generator:
  - 20-bit counter runs in PLAY only. When counter = half_period-1: counter=0, speaker toggles.
  - Counter and speaker are cleared on entry to FETCH, so every note starts with speaker=0 (phase-aligned).
  - Repeated identical notes still restart phase.
- playing=1 in FETCH and PLAY, else 0.
- address is a registered output and changes only on step, restart or reset.
- Reset asserted mid-note: all outputs return to reset values asynchronously.

Test Plan:
- TEMPO_DIV=8, ROM model with 2-cycle latency: address reads 0,1,2,… with one increment every 10 clk; speaker stays 0 during each 2-cycle FETCH.
- note_in=25 (octave 2, C#): half_period=180375; speaker toggles every 180375 clk in PLAY (use TEMPO_DIV=400000). note 12 -> toggles every 382204.
- note_in=0 and note_in=100: speaker remains 0 for the whole step; playing=1.
- LOOP=0, LAST_ADDR=3, TEMPO_DIV=8: after address 3 finishes, done=1, speaker=0, address=3 held. A restart pulse gives address=0, done=0, playing=1.
- LOOP=1, LAST_ADDR=3: address sequence 0,1,2,3,0,1; done never asserts.
- enable dropped mid-PLAY at address 5: next cycle speaker=0, playing=0, address=5. Re-enable enters FETCH at address 5. Reset asserted asynchronously mid-note: all outputs read 0 before the next clk edge.
